btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Parametrised, tagged branch target buffer with per-entry saturating direction counters.
- Sits beside the fetch stage: pc[IF] drives the lookup, and the prediction is consumed one cycle later in IG.
- The resolved branch outcome from the writeback-side stage drives the update port.
- Replaces the untagged, counterless direct-mapped BTB.
- Adds aliasing rejection, hysteresis, flush, and a post-reset clear sweep.

Parameters:
- PC_WIDTH, 32, program counter width.
- ENTRY_BITS, 10, log2 of entry count; index = pc[2 +: ENTRY_BITS].
- TAG_BITS, 8, tag = pc[2+ENTRY_BITS +: TAG_BITS]; requires 2+ENTRY_BITS+TAG_BITS <= PC_WIDTH.
- CTR_BITS, 2, saturating counter width (>=1); predict taken when counter MSB = 1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-low.
- ready, output, 1, 1 when the clear sweep is done and the predictor is live.
- lookup_pc, input, PC_WIDTH, fetch PC, sampled every cycle.
- pred_hit, output, 1, registered: valid entry with matching tag.
- pred_taken, output, 1, registered: pred_hit AND counter MSB.
- pred_next_pc, output, PC_WIDTH, registered: stored target if pred_taken, else lookup_pc+4.
- upd_en, input, 1, resolved control-flow event this cycle.
- upd_pc, input, PC_WIDTH, PC of the resolved instruction.
- upd_is_branch, input, 1, 1 = instruction is a branch/jump; 0 = non-branch that was predicted (alias scrub).
- upd_taken, input, 1, actual direction.
- upd_target, input, PC_WIDTH, actual taken target.
- flush, input, 1, invalidate all entries (e.g. on imem rewrite).

Behaviour:
- Entry layout: {valid, tag[TAG_BITS], ctr[CTR_BITS], target[PC_WIDTH-2]}. The target is stored word-aligned; low 2 bits of the output are 00.
- Reset (rst=0, async): state=CLEAR, sweep index=0, ready=0, pred_hit=0, pred_taken=0, pred_next_pc=0, update pipeline emptied.
- CLEAR state:
  - Writes valid=0 to one entry per cycle, index 0 up to 2^ENTRY_BITS-1.
  - After the last index, moves to RUN and ready=1 on the next cycle.
  - While in CLEAR, lookups return pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4, and upd_en is ignored (dropped).
- flush:
  - Asserted in RUN: goes to CLEAR with index=0 next cycle; ready drops the cycle after flush is sampled; any pending update is discarded.
  - Asserted in CLEAR: restarts the sweep at index 0.
- Lookup:
  - 1-cycle latency, one lookup per cycle, fully pipelined; pred_* reflect the lookup_pc of the previous cycle.
  - Read-before-write: a lookup and a write to the same index in the same cycle return the old entry.
- Update is a 2-stage pipeline.
  - U1 (cycle upd_en sampled) registers the update and reads the entry at upd index.
  - U2 (next cycle) computes and writes the entry:
    - is_branch, hit (valid and tag equal): ctr saturating +1 if taken, -1 if not taken; target replaced when taken.
    - is_branch, miss, taken: allocate with valid=1, new tag, ctr = 2^(CTR_BITS-1) (weakly taken), target.
    - is_branch, miss, not taken: no write.
    - not is_branch, hit: write valid=0.
    - not is_branch, miss: no write.
  - Saturation: ctr never wraps; max 2^CTR_BITS-1, min 0.
  - Back-to-back updates to the same index: U1 must use U2's pending write data instead of the stale RAM read (forwarding). Consecutive updates to one entry therefore accumulate.
  - One update accepted per cycle, with no stall.
- Simultaneous upd_en and flush: flush wins and the update is dropped.
- Tag compare uses the full TAG_BITS; differing upper PC bits beyond the tag field alias silently.

Test Plan:
- Reset, then idle with ENTRY_BITS=4 -> ready=0 for exactly 16 cycles after reset deassert, then 1; a lookup at 0x40 during the sweep gives pred_hit=0 and pred_next_pc=0x44.
- Update pc=0x100, taken, target=0x200; then lookup 0x100 -> pred_hit=1, pred_taken=1, pred_next_pc=0x200 one cycle after lookup.
- Same entry with CTR_BITS=2: three not-taken updates on consecutive cycles -> ctr 2→1→0→0 via forwarding; lookup gives pred_taken=0, pred_next_pc=0x104. Two taken updates -> ctr=2, predicts taken again.
- Alias: entry at 0x100 installed; lookup pc = 0x100 + (1<<(2+ENTRY_BITS)) -> pred_hit=0. An upd_is_branch=0 update at 0x100 -> subsequent lookup 0x100 misses.
- Not-taken update on an empty entry (pc=0x300) -> no allocation; lookup misses and returns 0x304.
- flush with 3 valid entries, plus flush concurrent with an upd_en -> ready=0 for 16 cycles, all lookups miss afterwards, dropped update not installed. An async rst pulse mid-sweep restarts the sweep at index 0 with outputs zeroed immediately.

Source files
------------

// File: rtl/btb_predictor.sv
// Tagged branch target buffer with saturating direction counters.
// Lookup is one cycle; updates use a two-stage read/modify/write pipe.
module btb_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int ENTRY_BITS = 10,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_next_pc,
    input  logic                upd_en,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_is_branch,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target,
    input  logic                flush
);

    localparam int N  = 1 << ENTRY_BITS;
    localparam int TW = PC_WIDTH - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [ENTRY_BITS-1:0] IDX_LAST = {ENTRY_BITS{1'b1}};

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ENTRY_BITS-1:0] clr_idx_q, clr_idx_d;

    logic                mem_v   [N];
    logic [TAG_BITS-1:0] mem_tag [N];
    logic [CTR_BITS-1:0] mem_ctr [N];
    logic [TW-1:0]       mem_tgt [N];

    logic                  running;
    logic [ENTRY_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0]   lk_tag, up_tag;
    logic                  lk_hit, lk_taken;
    logic [PC_WIDTH-1:0]   lk_next;

    logic                  u_vld_q;
    logic [ENTRY_BITS-1:0] u_idx_q;
    logic [TAG_BITS-1:0]   u_tag_q;
    logic                  u_br_q, u_tk_q;
    logic [TW-1:0]         u_tgt_q;
    logic                  rd_v_q;
    logic [TAG_BITS-1:0]   rd_tag_q;
    logic [CTR_BITS-1:0]   rd_ctr_q;
    logic [TW-1:0]         rd_tgt_q;

    logic                  accept, u_hit, fwd;
    logic                  wr_en, wr_v;
    logic [CTR_BITS-1:0]   wr_ctr;
    logic [TW-1:0]         wr_tgt;
    logic                  rd_v_d;
    logic [TAG_BITS-1:0]   rd_tag_d;
    logic [CTR_BITS-1:0]   rd_ctr_d;
    logic [TW-1:0]         rd_tgt_d;

    logic unused_bits;
    assign unused_bits = ^{lookup_pc, upd_pc, upd_target[1:0]};

    assign running = (state_q == S_RUN);
    assign ready   = running;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_LAST) state_d = S_RUN;
            end
            S_RUN: ;
            default: state_d = S_CLEAR;
        endcase
        if (flush) begin
            state_d   = S_CLEAR;
            clr_idx_d = '0;
        end
    end

    assign lk_idx = lookup_pc[2 +: ENTRY_BITS];
    assign lk_tag = lookup_pc[2+ENTRY_BITS +: TAG_BITS];
    assign up_idx = upd_pc[2 +: ENTRY_BITS];
    assign up_tag = upd_pc[2+ENTRY_BITS +: TAG_BITS];

    assign lk_hit   = running && mem_v[lk_idx] &&
                      (mem_tag[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && mem_ctr[lk_idx][CTR_BITS-1];
    assign lk_next  = lk_taken ? {mem_tgt[lk_idx], 2'b00}
                               : lookup_pc + PC_WIDTH'(4);

    assign accept = upd_en && running && !flush;
    assign u_hit  = rd_v_q && (rd_tag_q == u_tag_q);

    always_comb begin
        wr_en  = 1'b0;
        wr_v   = 1'b1;
        wr_ctr = rd_ctr_q;
        wr_tgt = rd_tgt_q;
        if (u_vld_q && !flush) begin
            if (u_br_q) begin
                if (u_hit) begin
                    wr_en = 1'b1;
                    if (u_tk_q) begin
                        wr_tgt = u_tgt_q;
                        if (rd_ctr_q != CTR_MAX) wr_ctr = rd_ctr_q + 1'b1;
                    end else if (rd_ctr_q != '0) begin
                        wr_ctr = rd_ctr_q - 1'b1;
                    end
                end else if (u_tk_q) begin
                    wr_en  = 1'b1;
                    wr_ctr = CTR_INIT;
                    wr_tgt = u_tgt_q;
                end
            end else if (u_hit) begin
                wr_en = 1'b1;
                wr_v  = 1'b0;
            end
        end
    end

    // U2's in-flight write shadows the array so same-index updates chain.
    assign fwd = wr_en && (u_idx_q == up_idx);

    always_comb begin
        rd_v_d   = mem_v[up_idx];
        rd_tag_d = mem_tag[up_idx];
        rd_ctr_d = mem_ctr[up_idx];
        rd_tgt_d = mem_tgt[up_idx];
        if (fwd) begin
            rd_v_d   = wr_v;
            rd_tag_d = u_tag_q;
            rd_ctr_d = wr_ctr;
            rd_tgt_d = wr_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CLEAR;
            clr_idx_q    <= '0;
            pred_hit     <= 1'b0;
            pred_taken   <= 1'b0;
            pred_next_pc <= '0;
            u_vld_q      <= 1'b0;
            u_idx_q      <= '0;
            u_tag_q      <= '0;
            u_br_q       <= 1'b0;
            u_tk_q       <= 1'b0;
            u_tgt_q      <= '0;
            rd_v_q       <= 1'b0;
            rd_tag_q     <= '0;
            rd_ctr_q     <= '0;
            rd_tgt_q     <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            pred_hit     <= lk_hit;
            pred_taken   <= lk_taken;
            pred_next_pc <= lk_next;
            u_vld_q      <= accept;
            if (accept) begin
                u_idx_q  <= up_idx;
                u_tag_q  <= up_tag;
                u_br_q   <= upd_is_branch;
                u_tk_q   <= upd_taken;
                u_tgt_q  <= upd_target[PC_WIDTH-1:2];
                rd_v_q   <= rd_v_d;
                rd_tag_q <= rd_tag_d;
                rd_ctr_q <= rd_ctr_d;
                rd_tgt_q <= rd_tgt_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_v[clr_idx_q] <= 1'b0;
        end else if (wr_en) begin
            mem_v[u_idx_q]   <= wr_v;
            mem_tag[u_idx_q] <= u_tag_q;
            mem_ctr[u_idx_q] <= wr_ctr;
            mem_tgt[u_idx_q] <= wr_tgt;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor with a 16-entry table.
// Covers sweep, counters, forwarding, aliasing, scrub, flush and reset.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_en, upd_is_branch, upd_taken, flush;
    logic [31:0] upd_pc, upd_target;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    btb_predictor #(
        .PC_WIDTH  (32),
        .ENTRY_BITS(4),
        .TAG_BITS  (8),
        .CTR_BITS  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .lookup_pc    (lookup_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_en       (upd_en),
        .upd_pc       (upd_pc),
        .upd_is_branch(upd_is_branch),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic br,
                          input logic tk, input logic [31:0] tgt);
        upd_en        = 1'b1;
        upd_pc        = pc;
        upd_is_branch = br;
        upd_taken     = tk;
        upd_target    = tgt;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic tk,
                        input logic [31:0] nxt);
        lookup_pc = pc;
        tick();
        chk({tag, ".hit"}, 32'(pred_hit), 32'(hit));
        chk({tag, ".tk"}, 32'(pred_taken), 32'(tk));
        chk({tag, ".nxt"}, pred_next_pc, nxt);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!ready && cnt < 100);
    endtask

    logic [31:0] gone [5];

    initial begin
        rst = 1'b0; flush = 1'b0; upd_en = 1'b0;
        upd_pc = '0; upd_is_branch = 1'b0; upd_taken = 1'b0;
        upd_target = '0; lookup_pc = 32'h40;
        tick(); tick();
        chk("rst.ready", 32'(ready), 0);
        chk("rst.hit", 32'(pred_hit), 0);
        chk("rst.tk", 32'(pred_taken), 0);
        chk("rst.nxt", pred_next_pc, 0);

        rst = 1'b1;
        tick();
        chk("sweep.ready", 32'(ready), 0);
        chk("sweep.hit", 32'(pred_hit), 0);
        chk("sweep.nxt", pred_next_pc, 32'h44);
        wait_ready(n);
        chk("sweep.len", 32'(n + 1), 16);

        do_upd(32'h100, 1, 1, 32'h200);
        tick();
        look("inst", 32'h100, 1, 1, 32'h200);

        do_upd(32'h100, 1, 0, 32'h0);
        do_upd(32'h100, 1, 0, 32'h0);
        do_upd(32'h100, 1, 0, 32'h0);
        tick();
        look("nt3", 32'h100, 1, 0, 32'h104);
        do_upd(32'h100, 1, 1, 32'h200);
        do_upd(32'h100, 1, 1, 32'h200);
        tick();
        look("t2", 32'h100, 1, 1, 32'h200);

        do_upd(32'h100, 1, 1, 32'h200);
        do_upd(32'h100, 1, 1, 32'h200);
        do_upd(32'h100, 1, 0, 32'h0);
        tick();
        look("sathi", 32'h100, 1, 1, 32'h200);
        do_upd(32'h100, 1, 0, 32'h0);
        do_upd(32'h100, 1, 0, 32'h0);
        tick();
        look("down", 32'h100, 1, 0, 32'h104);

        look("alias", 32'h140, 0, 0, 32'h144);
        do_upd(32'h100, 0, 0, 32'h0);
        tick();
        look("scrub", 32'h100, 0, 0, 32'h104);

        do_upd(32'h300, 1, 0, 32'h500);
        tick();
        look("ntmiss", 32'h300, 0, 0, 32'h304);

        do_upd(32'h110, 1, 1, 32'h400);
        lookup_pc = 32'h110;
        tick();
        chk("rbw.old", 32'(pred_hit), 0);
        chk("rbw.nxt", pred_next_pc, 32'h114);
        tick();
        chk("rbw.new", 32'(pred_hit), 1);
        chk("rbw.tgt", pred_next_pc, 32'h400);

        do_upd(32'h100, 1, 1, 32'h200);
        do_upd(32'h104, 1, 1, 32'h204);
        do_upd(32'h108, 1, 1, 32'h208);
        tick();
        look("pre", 32'h104, 1, 1, 32'h204);

        do_upd(32'h118, 1, 1, 32'h600);
        flush = 1'b1; upd_en = 1'b1;
        upd_pc = 32'h10C; upd_is_branch = 1'b1;
        upd_taken = 1'b1; upd_target = 32'h30C;
        tick();
        flush = 1'b0; upd_en = 1'b0;
        chk("fl.ready", 32'(ready), 0);
        wait_ready(n);
        chk("fl.len", 32'(n), 16);
        gone[0] = 32'h100; gone[1] = 32'h104; gone[2] = 32'h108;
        gone[3] = 32'h10C; gone[4] = 32'h118;
        for (int i = 0; i < 5; i++)
            look("gone", gone[i], 0, 0, gone[i] + 32'h4);

        do_upd(32'h120, 1, 1, 32'h7F0);
        tick();
        flush = 1'b1;
        lookup_pc = 32'h80;
        tick();
        flush = 1'b0;
        tick(); tick(); tick();
        chk("mid.nxt", pred_next_pc, 32'h84);
        #2 rst = 1'b0;
        #1;
        chk("arst.ready", 32'(ready), 0);
        chk("arst.hit", 32'(pred_hit), 0);
        chk("arst.nxt", pred_next_pc, 0);
        tick();
        rst = 1'b1;
        wait_ready(n);
        chk("arst.len", 32'(n), 16);
        look("arst.gone", 32'h120, 0, 0, 32'h124);

        do_upd(32'h120, 1, 1, 32'h7F0);
        tick();
        look("live", 32'h120, 1, 1, 32'h7F0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
